// File: rtl/mac_pkg.sv
// Shared FP16 field widths, alignment widths and mantissa decode for the MAC datapath.
package mac_pkg;
    localparam int N_OPS  = 9;
    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int GUARD  = 3;
    localparam int MAG_W  = FRAC_W + 1 + GUARD;
    localparam int OUT_W  = MAG_W + 1;

    typedef logic [MAG_W-1:0] mag_t;
    typedef logic [OUT_W-1:0] amant_t;

    // Zero exponent flushes to zero (subnormals included); otherwise restore
    // the hidden bit and append GUARD zero bits for the alignment shift.
    function automatic mag_t fp16_mant(input logic [EXP_W-1:0] exp,
                                       input logic [FRAC_W-1:0] frac);
        mag_t m;
        m = '0;
        if (exp != '0) begin
            m = {1'b1, frac, {GUARD{1'b0}}};
        end
        return m;
    endfunction
endpackage

// File: rtl/fp_align_lane.sv
// One operand lane: right-shift the decoded mantissa to the shared exponent,
// fold shifted-out bits into a sticky LSB, then apply the sign.
module fp_align_lane
    import mac_pkg::*;
(
    input  logic             sign,
    input  logic [EXP_W-1:0] exp,
    input  logic [EXP_W-1:0] exp_max,
    input  mag_t             mant,
    output amant_t           aligned
);
    logic [EXP_W-1:0] shift;
    mag_t             shifted;
    mag_t             lost_mask;
    mag_t             mag;
    logic             sticky;

    // For shift >= MAG_W the mask covers every bit, so the result collapses
    // to the sticky bit alone without a separate branch.
    always_comb begin
        shift     = exp_max - exp;
        shifted   = mant >> shift;
        lost_mask = ~({MAG_W{1'b1}} << shift);
        sticky    = |(mant & lost_mask);
        mag       = {shifted[MAG_W-1:1], shifted[0] | sticky};
        aligned   = sign ? amant_t'(-{1'b0, mag}) : {1'b0, mag};
    end
endmodule

// File: rtl/max_exponent.sv
// Combinational maximum over N_OPS packed biased exponents.
module max_exponent
    import mac_pkg::*;
(
    input  logic [N_OPS*EXP_W-1:0] exp_in,
    output logic [EXP_W-1:0]       exp_max
);
    // Linear scan; nine 5-bit compares keep this shallow enough for one stage.
    always_comb begin
        exp_max = '0;
        for (int i = 0; i < N_OPS; i++) begin
            if (exp_in[i*EXP_W +: EXP_W] > exp_max) begin
                exp_max = exp_in[i*EXP_W +: EXP_W];
            end
        end
    end
endmodule

// File: rtl/fp16_align_stage.sv
// Two-stage FP16 alignment: S1 captures decoded operands and the max exponent,
// S2 captures the nine signed aligned mantissas with their shared exponent.
module fp16_align_stage
    import mac_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_OPS-1:0]        in_sign,
    input  logic [N_OPS*EXP_W-1:0]  in_exp,
    input  logic [N_OPS*FRAC_W-1:0] in_frac,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W-1:0]        out_exp_max,
    output logic [N_OPS*OUT_W-1:0]  out_mant
);
    logic                    s1_valid_reg;
    logic [N_OPS-1:0]        s1_sign_reg;
    logic [N_OPS*EXP_W-1:0]  s1_exp_reg;
    logic [N_OPS*MAG_W-1:0]  s1_mant_reg;
    logic [EXP_W-1:0]        s1_exp_max_reg;

    logic                    s2_valid_reg;
    logic [N_OPS*OUT_W-1:0]  s2_mant_reg;
    logic [EXP_W-1:0]        s2_exp_max_reg;

    logic [N_OPS*MAG_W-1:0]  s1_mant_next;
    logic [EXP_W-1:0]        s1_exp_max_next;
    logic [N_OPS*OUT_W-1:0]  s2_mant_next;
    logic                    s1_en;
    logic                    s2_en;

    // A stage may load when it is empty or its contents move on this edge.
    assign s2_en    = !s2_valid_reg || out_ready;
    assign s1_en    = !s1_valid_reg || s2_en;
    assign in_ready = s1_en;

    max_exponent u_max_exponent (
        .exp_in  (in_exp),
        .exp_max (s1_exp_max_next)
    );

    for (genvar gi = 0; gi < N_OPS; gi++) begin : g_lane
        assign s1_mant_next[gi*MAG_W +: MAG_W] =
            fp16_mant(in_exp[gi*EXP_W +: EXP_W], in_frac[gi*FRAC_W +: FRAC_W]);

        fp_align_lane u_lane (
            .sign    (s1_sign_reg[gi]),
            .exp     (s1_exp_reg[gi*EXP_W +: EXP_W]),
            .exp_max (s1_exp_max_reg),
            .mant    (s1_mant_reg[gi*MAG_W +: MAG_W]),
            .aligned (s2_mant_next[gi*OUT_W +: OUT_W])
        );
    end

    // S1: capture decoded operands and their max exponent on input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            s1_sign_reg    <= '0;
            s1_exp_reg     <= '0;
            s1_mant_reg    <= '0;
            s1_exp_max_reg <= '0;
        end else if (s1_en) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_sign_reg    <= in_sign;
                s1_exp_reg     <= in_exp;
                s1_mant_reg    <= s1_mant_next;
                s1_exp_max_reg <= s1_exp_max_next;
            end
        end
    end

    // S2: capture aligned results; data only changes when a new item arrives,
    // so outputs hold steady through a downstream stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg   <= 1'b0;
            s2_mant_reg    <= '0;
            s2_exp_max_reg <= '0;
        end else if (s2_en) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_mant_reg    <= s2_mant_next;
                s2_exp_max_reg <= s1_exp_max_reg;
            end
        end
    end

    assign out_valid   = s2_valid_reg;
    assign out_mant    = s2_mant_reg;
    assign out_exp_max = s2_exp_max_reg;
endmodule

// File: tb/tb_fp16_align_stage.sv
// Directed bench for fp16_align_stage: single-transaction alignment cases,
// a stalled back-to-back stream, and asynchronous reset with a full pipeline.
module tb_fp16_align_stage;
    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [8:0]   in_sign;
    logic [44:0]  in_exp;
    logic [89:0]  in_frac;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   out_exp_max;
    logic [134:0] out_mant;

    int tests_run;
    int tests_failed;

    fp16_align_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_frac     (in_frac),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_exp_max (out_exp_max),
        .out_mant    (out_mant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one transaction into an empty pipeline with out_ready=1 and
    // report how many edges (accept edge counted as 1) until out_valid.
    task automatic run_one(input logic [8:0] s, input logic [44:0] e,
                           input logic [89:0] f, output int lat,
                           output logic [4:0] gx, output logic [134:0] gm);
        lat = -1;
        gx  = '0;
        gm  = '0;
        @(negedge clk);
        in_sign   = s;
        in_exp    = e;
        in_frac   = f;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (out_valid) begin
                lat = c;
                gx  = out_exp_max;
                gm  = out_mant;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sign = '0; in_exp = '0; in_frac = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_mant !== '0 || out_exp_max !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b exp=%h mant=%h, want 0/0/0", out_valid, out_exp_max, out_mant);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_all_ones();
        int lat; logic [4:0] gx; logic [134:0] gm;
        run_one(9'h000, {9{5'd15}}, '0, lat, gx, gm);
        tests_run++;
        if (lat !== 2) begin
            tests_failed++;
            $display("FAIL ones_latency: got %0d want 2", lat);
        end
        tests_run++;
        if (gx !== 5'd15 || gm !== {9{15'h2000}}) begin
            tests_failed++;
            $display("FAIL ones_data: exp=%h mant=%h want exp=0f mant=%h", gx, gm, {9{15'h2000}});
        end
        $display("[TB] all_ones: lat=%0d exp=%h", lat, gx);
    endtask

    task automatic test_sign();
        int lat; logic [4:0] gx; logic [134:0] gm; logic [44:0] e; logic [134:0] want;
        e = '0; e[4:0] = 5'd15; e[9:5] = 5'd14;
        want = '0; want[14:0] = 15'h2000; want[29:15] = 15'h7000;
        run_one(9'h002, e, '0, lat, gx, gm);
        tests_run++;
        if (gx !== 5'd15 || gm !== want) begin
            tests_failed++;
            $display("FAIL sign_data: exp=%h mant=%h want exp=0f mant=%h", gx, gm, want);
        end
        $display("[TB] sign: exp=%h lane1=%h", gx, gm[29:15]);
    endtask

    task automatic test_sticky_far();
        int lat; logic [4:0] gx; logic [134:0] gm; logic [44:0] e; logic [89:0] f; logic [134:0] want;
        e = '0; e[4:0] = 5'd30; e[9:5] = 5'd10;
        f = '0; f[19:10] = 10'h3FF;
        want = '0; want[14:0] = 15'h2000; want[29:15] = 15'h0001;
        run_one(9'h000, e, f, lat, gx, gm);
        tests_run++;
        if (gx !== 5'd30) begin
            tests_failed++;
            $display("FAIL sticky_exp: got %h want 1e", gx);
        end
        tests_run++;
        if (gm !== want) begin
            tests_failed++;
            $display("FAIL sticky_mant: got %h want %h", gm, want);
        end
        $display("[TB] sticky_far: exp=%h lane1=%h", gx, gm[29:15]);
    endtask

    task automatic test_exact_shift();
        int lat; logic [4:0] gx; logic [134:0] gm; logic [44:0] e; logic [89:0] f; logic [134:0] want;
        e = '0; e[4:0] = 5'd15; e[9:5] = 5'd13;
        f = '0; f[9:0] = 10'h001; f[19:10] = 10'h001;
        want = '0; want[14:0] = 15'h2008; want[29:15] = 15'h0802;
        run_one(9'h000, e, f, lat, gx, gm);
        tests_run++;
        if (gx !== 5'd15 || gm !== want) begin
            tests_failed++;
            $display("FAIL exact_shift: exp=%h mant=%h want exp=0f mant=%h", gx, gm, want);
        end
        $display("[TB] exact_shift: lane0=%h lane1=%h", gm[14:0], gm[29:15]);
    endtask

    // Txn k: lane0 exp=20 frac=k sign=k[0]; lane8 exp=20-k; other lanes zero.
    task automatic test_back_to_back();
        int sent, recv, cyc;
        logic [3:0] pat;
        logic v, r, iv, ir, stalled;
        logic [134:0] m, pm, want;
        logic [4:0] x, px;
        logic [14:0] l0;
        logic [9:0] kf;
        sent = 0; recv = 0; cyc = 0; pat = 4'b1001; stalled = 1'b0;
        pm = '0; px = '0;
        while (recv < 8 && cyc < 200) begin
            @(negedge clk);
            out_ready = pat[cyc % 4];
            if (sent < 8) begin
                in_valid = 1'b1;
                in_sign = '0; in_sign[0] = sent[0];
                in_exp = '0; in_exp[4:0] = 5'd20; in_exp[44:40] = 5'(20 - sent);
                in_frac = '0; in_frac[9:0] = 10'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            tests_run++;
            if (in_ready !== !((sent - recv) == 2 && !out_ready)) begin
                tests_failed++;
                $display("FAIL b2b_in_ready: cyc %0d got %b inflight %0d out_ready %b", cyc, in_ready, sent - recv, out_ready);
            end
            if (stalled) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_mant !== pm || out_exp_max !== px) begin
                    tests_failed++;
                    $display("FAIL b2b_stall_hold: cyc %0d valid=%b mant=%h want held %h", cyc, out_valid, out_mant, pm);
                end
            end
            v = out_valid; r = out_ready; iv = in_valid; ir = in_ready;
            m = out_mant; x = out_exp_max;
            @(posedge clk);
            if (v && r) begin
                kf = 10'(recv);
                l0 = {2'b01, kf, 3'b000};
                if (kf[0]) l0 = -l0;
                want = '0;
                want[14:0] = l0;
                want[134:120] = 15'h2000 >> recv;
                tests_run++;
                if (x !== 5'd20 || m !== want) begin
                    tests_failed++;
                    $display("FAIL b2b_result%0d: exp=%h mant=%h want exp=14 mant=%h", recv, x, m, want);
                end
                $display("[TB] b2b result %0d: lane0=%h lane8=%h", recv, m[14:0], m[134:120]);
                recv++;
            end
            if (iv && ir) sent++;
            stalled = v && !r;
            pm = m; px = x;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tests_run++;
        if (sent != 8 || recv != 8) begin
            tests_failed++;
            $display("FAIL b2b_count: sent %0d recv %0d want 8/8", sent, recv);
        end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_no_extra: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_sign = '0; in_exp = {9{5'd15}}; in_frac = '0;
        @(negedge clk);
        in_exp = {9{5'd16}};
        @(posedge clk);
        #1 in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_fill: valid=%b in_ready=%b want 1/0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_mant !== '0 || out_exp_max !== '0) begin
            tests_failed++;
            $display("FAIL arst_immediate: valid=%b exp=%h mant=%h want 0/0/0", out_valid, out_exp_max, out_mant);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL arst_after: cyc %0d valid=%b in_ready=%b want 0/1", c, out_valid, in_ready);
            end
        end
        $display("[TB] async reset done");
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_all_ones();
        test_sign();
        test_sticky_far();
        test_exact_shift();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/fp16_align_stage.md
Name: fp16_align_stage

Overview:
- Pipelined alignment stage of the SD4 MAC datapath. It accepts nine FP16 operands (sign, 5-bit biased exponent, 10-bit fraction) per transaction over a valid/ready handshake.
- It finds the maximum exponent using the existing max_exponent block and right-shifts every mantissa to that exponent, keeping guard and sticky bits.
- It emits nine signed, aligned mantissas plus the shared exponent to the downstream fixed-point adder tree.

Parameters:
- N_OPS, 9, operands per transaction; fixed at 9 to match max_exponent.
- GUARD, 3, extra LSBs appended below the 11-bit mantissa before shifting.
- MAG_W, 11+GUARD (14), aligned magnitude width.
- OUT_W, MAG_W+1 (15), signed aligned-mantissa width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input transaction valid.
- in_ready  output  1  stage can accept a transaction.
- in_sign  input  9  sign bit of operand i at bit i.
- in_exp  input  45  exponent i at [5i+4:5i].
- in_frac  input  90  fraction i at [10i+9:10i].
- out_valid  output  1  aligned result valid.
- out_ready  input  1  downstream accepts the result.
- out_exp_max  output  5  shared maximum exponent.
- out_mant  output  135  signed aligned mantissa i at [15i+14:15i].

Behaviour:
- Reset: assert rst_n low, asynchronously.
  - Clears s1_valid, s2_valid and all pipeline data registers.
  - out_valid=0, out_exp_max=0, out_mant=0.
  - in_ready=1 from the first cycle after release.
  - Reset mid-transaction discards all in-flight data; nothing is emitted afterwards.
- Handshake:
  - A transfer occurs when valid&&ready on a rising clk edge.
  - out_valid/out_exp_max/out_mant stay stable while out_valid && !out_ready.
  - The input side is not required to hold data when in_ready=0, but must hold it if in_valid is kept high.
- Pipeline, two register stages:
  - S1 registers the operands, the per-operand mantissa {hidden,frac,GUARD zeros} and max_exponent(in_exp).
  - S2 registers the shifted, signed results.
  - Stage advance rules:
    - s2_en = !s2_valid || out_ready.
    - s1_en = !s1_valid || s2_en.
    - in_ready = s1_en (combinational).
  - Latency is 2 cycles from input acceptance to out_valid with no stall. Throughput is 1 transaction/cycle.
  - Simultaneous accept at S1 and drain at S2 in one cycle is legal and must lose no data.
- Operand decode:
  - exp==0: treated as zero (flush-to-zero, including subnormals); mantissa=0, exponent still counts as 0 in the max.
  - exp!=0: mantissa = {1'b1, frac, GUARD'b0}.
  - exp==31 (inf/NaN) is not special-cased; it is aligned as an ordinary value.
- Alignment per operand: shift = exp_max - exp_i (0..31, never negative).
  - shift < MAG_W: mag = mant >> shift; sticky = OR of shifted-out bits, ORed into mag[0].
  - shift >= MAG_W: mag = (mant != 0) ? 1 : 0 (sticky only).
  - shift == 0: mag = mant unchanged.
- Sign: out = sign ? -{1'b0,mag} : {1'b0,mag}, OUT_W-bit two's complement. Negative zero yields 0.
- out_exp_max is carried alongside its mantissas through S2.

Decomposition:
- Shared package mac_pkg: FP16 field widths (EXP_W=5, FRAC_W=10), GUARD, MAG_W and OUT_W, plus a typedef for the aligned-mantissa type.
- Sub-modules:
  - fp_align_lane: combinational single-operand decode, shift with sticky, and sign conversion; instantiated N_OPS times in the S2 input logic.
  - The existing max_exponent module is instantiated once before S1.

Test Plan:
- Single transaction, all operands 1.0 (exp=15, frac=0, sign=0) with out_ready=1 -> out_valid two cycles after accept; out_exp_max=15; every lane 0x2000.
- Lane0 exp=15, lane1 exp=14 with sign=1, others exp=0 -> exp_max=15; lane0=0x2000; lane1=-0x1000 (15'h7000); other lanes 0.
- Lane0 exp=30, lane1 exp=10 frac=0x3FF, others exp=0 -> shift 20 >= MAG_W; lane1=0x0001 (sticky only); exp_max=30.
- Lane0 exp=15 frac=0x001, lane1 exp=13 frac=0x001 -> lane1 mantissa 0x2008 >>2 = 0x802 with no bits lost; lane1=0x0802.
- Back-to-back stream of 8 transactions with out_ready toggled 1,0,0,1,... -> in_ready drops only when both stages are full; results arrive in order, none lost or duplicated, data stable during stalls.
- Assert rst_n low with both stages full -> out_valid=0 and out_mant=0 immediately (asynchronous); no stale output after release; in_ready=1.
